mmio_irq_timer: RTL and testbench

//  Memory-mapped interrupt source on the MIPS data bus: responder to CPU stores (memwrite/dataadr/writedata).

---
 rtl/mmio_irq_timer_if.sv | 10 +
 rtl/mmio_irq_timer.sv | 67 ++++++
 tb/tb_mmio_irq_timer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mmio_irq_timer_if.sv
// mmio_irq_timer_if: CPU data-bus signals seen by a memory-mapped responder
interface mmio_irq_timer_if;
  logic        memwrite;
  logic        memread;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output memwrite, memread, dataadr, writedata, input readdata);
  modport slave  (input memwrite, memread, dataadr, writedata, output readdata);
endinterface

// File: rtl/mmio_irq_timer.sv
// mmio_irq_timer: compare-match timer and software triggers driving pulsed CPU interrupt lines
module mmio_irq_timer #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000,
  parameter int          NUM_IRQ      = 8,
  parameter int          PULSE_CYCLES = 5
) (
  input  logic                ph1,
  input  logic                reset,
  mmio_irq_timer_if.slave     bus,
  output logic [NUM_IRQ-1:0]  interrupts
);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  logic               en_q, en_d, ar_q, ar_d;
  logic [2:0]         tline_q, tline_d;
  logic [31:0]        count_q, count_d, compare_q, compare_d, readdata_q, readdata_d;
  logic [NUM_IRQ-1:0] status_q, status_d, trig, w1c;
  logic [PW-1:0]      cnt_q [NUM_IRQ];
  logic [PW-1:0]      cnt_d [NUM_IRQ];
  logic               hit, wr, match;
  logic [2:0]         off;
  logic [31:0]        rd;
  // address decode, timer match and trigger/status/pulse next state
  always_comb begin
    hit = bus.dataadr[31:5] == BASE_ADDR[31:5];
    off = bus.dataadr[4:2];
    wr = bus.memwrite && hit;
    match = en_q && count_q == compare_q;
    en_d = (wr && off == 3'd0) ? bus.writedata[0] : en_q;
    ar_d = (wr && off == 3'd0) ? bus.writedata[1] : ar_q;
    tline_d = (wr && off == 3'd0) ? bus.writedata[10:8] : tline_q;
    count_d = (wr && off == 3'd1) ? bus.writedata : !en_q ? count_q : (match && ar_q) ? 32'd0 : count_q + 32'd1;
    compare_d = (wr && off == 3'd2) ? bus.writedata : compare_q;
    w1c = (wr && off == 3'd4) ? bus.writedata[NUM_IRQ-1:0] : '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      trig[i] = (match && tline_q == 3'(i)) || (wr && off == 3'd3 && bus.writedata[i]);
      cnt_d[i] = trig[i] ? PW'(PULSE_CYCLES) : (cnt_q[i] != '0) ? cnt_q[i] - PW'(1) : '0;
      interrupts[i] = cnt_q[i] != '0;
    end
    status_d = (status_q & ~w1c) | trig;
    rd = !hit ? 32'd0 : off == 3'd0 ? {21'd0, tline_q, 6'd0, ar_q, en_q} : off == 3'd1 ? count_q :
         off == 3'd2 ? compare_q : off == 3'd4 ? 32'(status_q) : 32'd0;
    readdata_d = bus.memread ? rd : readdata_q;
  end
  assign bus.readdata = readdata_q;
  // register state; reset clears everything including in-flight pulses
  always_ff @(posedge ph1) begin
    if (reset) begin
      en_q <= 1'b0;
      ar_q <= 1'b0;
      tline_q <= '0;
      count_q <= '0;
      compare_q <= 32'hFFFFFFFF;
      status_q <= '0;
      readdata_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      en_q <= en_d;
      ar_q <= ar_d;
      tline_q <= tline_d;
      count_q <= count_d;
      compare_q <= compare_d;
      status_q <= status_d;
      readdata_q <= readdata_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mmio_irq_timer.sv
// tb_mmio_irq_timer: directed stores/loads with hand-computed expectations
module tb_mmio_irq_timer;
  localparam logic [31:0] A_CTRL = 32'hFFFF0000, A_COUNT = 32'hFFFF0004, A_CMP = 32'hFFFF0008,
                          A_SW = 32'hFFFF000C, A_ST = 32'hFFFF0010, A_UNM = 32'hFFFF0014;
  logic       ph1 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] interrupts;
  int         pass_cnt = 0, total = 0, cyc = 0;
  logic [31:0] v;
  int         t1, t2, n;
  mmio_irq_timer_if bus ();
  mmio_irq_timer dut (.ph1(ph1), .reset(reset), .bus(bus.slave), .interrupts(interrupts));
  always #5 ph1 = ~ph1;
  // cycle stamp for period measurement
  always @(posedge ph1) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite = 1'b1; bus.dataadr = a; bus.writedata = d;
    @(negedge ph1);
    bus.memwrite = 1'b0;
  endtask
  task automatic load(input logic [31:0] a, output logic [31:0] d);
    bus.memread = 1'b1; bus.dataadr = a;
    @(negedge ph1);
    bus.memread = 1'b0;
    d = bus.readdata;
  endtask
  task automatic rise2(output int t);
    t = -1;
    for (int k = 0; k < 30; k++) begin
      if (!interrupts[2]) break;
      @(negedge ph1);
    end
    for (int k = 0; k < 30; k++) begin
      if (interrupts[2]) begin t = cyc; break; end
      @(negedge ph1);
    end
  endtask
  initial begin
    bus.memwrite = 1'b0; bus.memread = 1'b0; bus.dataadr = '0; bus.writedata = '0;
    repeat (3) @(negedge ph1);
    reset = 1'b0;
    chk("rst_irq", 32'(interrupts), 32'h0);
    load(A_CTRL, v);  chk("rst_ctrl", v, 32'h0);
    load(A_COUNT, v); chk("rst_count", v, 32'h0);
    load(A_ST, v);    chk("rst_status", v, 32'h0);
    load(A_CMP, v);   chk("rst_compare", v, 32'hFFFFFFFF);
    store(A_SW, 32'h2);
    for (int k = 0; k < 5; k++) begin
      chk("sw_pulse_high", 32'(interrupts), 32'h2);
      @(negedge ph1);
    end
    chk("sw_pulse_low", 32'(interrupts), 32'h0);
    load(A_ST, v); chk("sw_status", v, 32'h2);
    load(A_SW, v); chk("swirq_reads0", v, 32'h0);
    store(A_ST, 32'hFF);
    load(A_ST, v); chk("status_clr", v, 32'h0);
    store(A_SW, 32'h1);
    n = 1;
    @(negedge ph1); n++;
    @(negedge ph1); n++;
    store(A_SW, 32'h1);
    for (int k = 0; k < 20 && interrupts[0]; k++) begin
      n++;
      @(negedge ph1);
    end
    chk("retrig_len", 32'(n), 32'd8);
    store(A_ST, 32'hFF);
    store(A_CMP, 32'd10);
    store(A_COUNT, 32'd0);
    store(A_CTRL, 32'h0203);
    load(A_CTRL, v); chk("ctrl_read", v, 32'h0203);
    rise2(t1);
    rise2(t2);
    chk("t1_seen", 32'(t1 >= 0), 32'h1);
    chk("period", 32'(t2 - t1), 32'd11);
    n = 0;
    for (int k = 0; k < 20 && interrupts[2]; k++) begin
      n++;
      @(negedge ph1);
    end
    chk("timer_pulse_len", 32'(n), 32'd5);
    for (int k = 0; k < 15; k++) begin
      load(A_COUNT, v);
      chk("count_le10", 32'(v <= 32'd10), 32'h1);
    end
    store(A_CTRL, 32'h0);
    repeat (8) @(negedge ph1);
    store(A_ST, 32'hFF);
    store(A_SW, 32'h6);
    load(A_ST, v); chk("pend6", v, 32'h6);
    store(A_ST, 32'h4);
    load(A_ST, v); chk("w1c_one", v, 32'h2);
    store(A_CMP, 32'd2);
    store(A_COUNT, 32'd0);
    store(A_CTRL, 32'h0201);
    @(negedge ph1);
    @(negedge ph1);
    store(A_ST, 32'h6);
    load(A_ST, v); chk("w1c_vs_set", v, 32'h4);
    store(A_CTRL, 32'h0);
    bus.memread = 1'b1; bus.memwrite = 1'b1; bus.dataadr = A_CMP; bus.writedata = 32'h123;
    @(negedge ph1);
    bus.memread = 1'b0; bus.memwrite = 1'b0;
    chk("raw_prewrite", bus.readdata, 32'd2);
    load(A_CMP, v); chk("raw_after", v, 32'h123);
    load(A_UNM, v); chk("unmapped", v, 32'h0);
    load(32'h0000_0010, v); chk("miss", v, 32'h0);
    store(A_COUNT, 32'hFFFFFFFE);
    store(A_CTRL, 32'h1);
    load(A_COUNT, v); chk("wrap_fe", v, 32'hFFFFFFFE);
    load(A_COUNT, v); chk("wrap_ff", v, 32'hFFFFFFFF);
    load(A_COUNT, v); chk("wrap_0", v, 32'h0);
    store(A_CTRL, 32'h0F03);
    load(A_CTRL, v); chk("ctrl_mask", v, 32'h0703);
    store(A_SW, 32'h80);
    chk("pre_reset_irq", 32'(interrupts), 32'h80);
    reset = 1'b1;
    @(negedge ph1);
    chk("reset_irq", 32'(interrupts), 32'h0);
    reset = 1'b0;
    load(A_ST, v);    chk("reset_status", v, 32'h0);
    load(A_CMP, v);   chk("reset_compare", v, 32'hFFFFFFFF);
    load(A_CTRL, v);  chk("reset_ctrl", v, 32'h0);
    chk("reset_irq_stays", 32'(interrupts), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
